adc_sample_conditioner: RTL and testbench
=========================================

# adc_sample_conditioner

Conditions raw AD9226 capture samples before they reach the audio/FM-control stage. Takes 12-bit offset-binary words plus a valid strobe and converts them to signed. It optionally removes DC with a first-order leaky tracker, then box-car decimates by 2^DEC_LOG2. The output is a signed sample stream with a one-cycle valid pulse, sitting between each ADC capture channel and the audio handling block in the 50 MHz domain.

## Interface
- DATA_WIDTH, 12: sample width in and out.
- DEC_LOG2, 2: decimation factor is 2^DEC_LOG2. A value of 0 means every sample passes through.
- DC_SHIFT, 8: DC tracker time-constant shift; the tracker has DATA_WIDTH+DC_SHIFT bits.
- clk_in  input  1  sample-domain clock.
- RST  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  ADC word, offset binary.
- din_valid  input  1  din is accepted this cycle. At most one sample per cycle; gaps of any length are allowed; there is no backpressure.
- clr_clip  input  1  clears the sticky clip flag.
- dout  output  DATA_WIDTH  conditioned sample, two's complement.
- dout_valid  output  1  one-cycle pulse per decimated sample.
- clip  output  1  sticky flag: saturation has occurred.

## Operation
- Format conversion: x = din with its MSB inverted, treated as signed.
- Stage 1: on din_valid, register x_s and set v1. Otherwise v1 = 0.
- Stage 2 (when v1 is set): y = sat(x_s − dc_est). The subtraction is done at DATA_WIDTH+1 bits, then saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- A saturation event sets clip. If clip is set and cleared in the same cycle, set wins.
- DC tracker (FSM, present only with the macro):
  - INIT is the reset state. The first v1 sample preloads dc_acc = x_s <<< DC_SHIFT, uses y = 0, then moves to RUN.
  - In RUN: dc_acc ← dc_acc + x_s − (dc_acc >>> DC_SHIFT).
  - dc_est = dc_acc >>> DC_SHIFT, using the value before the update.
- Decimator:
  - sum has DATA_WIDTH+DEC_LOG2 bits; cnt has DEC_LOG2 bits.
  - On each y: if cnt is all-ones, output (sum+y) >>> DEC_LOG2 (arithmetic, floor), clear sum, and wrap cnt to 0. Otherwise sum += y and cnt++.
- dout holds its last value between pulses.

## Timing
- Reset values: dout = 0, dout_valid = 0, clip = 0, sum = 0, cnt = 0, dc_acc = 0, FSM = INIT.
- Latency: dout_valid rises exactly 2 clk_in cycles after the din_valid cycle of the last sample in a block.
- Throughput is one input per cycle, so dout_valid is never high for more than one consecutive cycle unless DEC_LOG2 = 0.
- RST mid-block discards the partial sum and the count. The next block starts with the next din_valid after reset.
- A din_valid in the same cycle as RST deassertion is accepted.

## Configuration
- COND_DC_BLOCK_EN defined: the DC tracker, the INIT/RUN FSM and the preload are built; y = sat(x − dc_est).
- COND_DC_BLOCK_EN undefined: the tracker and FSM are absent. y = x_s, which never saturates, so clip stays 0. The decimator and latency are unchanged.

## Structure
- Package cond_pkg contains:
  - the state enum {INIT, RUN};
  - the default width localparams;
  - a sat_signed function (input width → output width).
- Sub-module cond_dc_tracker (dc_acc, FSM, dc_est output) is instantiated only under COND_DC_BLOCK_EN.

## Test plan
Defaults are used unless a scenario states otherwise.
1. Reset: drive RST high with din_valid toggling → dout = 0, dout_valid = 0, clip = 0 throughout. After release, the first dout_valid appears 2 cycles after the 4th valid.
2. Macro off, inputs 0x801, 0x802, 0x803, 0x804 with din_valid every 3rd cycle → dout = 2 (10 >>> 2), pulsed 2 cycles after the 4th valid. Then 0x7FF ×4 → dout = 0xFFF (−1).
3. Macro on, constant 0xC00 (+1024) for 64 samples → preload gives y = 0, every dout = 0, clip = 0.
4. Macro on, 0x800 ×4, then a step to 0xC00 → first post-step block dout is in the range 1012..1024; later blocks decay monotonically toward 0.
5. Macro on, preload with 0xFFF (+2047), then 0x000 (−2048) → y saturates to −2048 and clip = 1. Asserting clr_clip in the same cycle leaves clip = 1; clr_clip alone on the next cycle gives clip = 0.
6. Reset after 2 of 4 samples, then 0x804 ×4 → dout = 4 (no residue from before reset). With the macro on, the FSM re-enters INIT and re-preloads.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types, default widths and the saturation helper for the
// ADC sample conditioner.
package cond_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } cond_state_e;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_DEC_LOG2   = 2;
  localparam int DEF_DC_SHIFT   = 8;

  // Clamp a signed value into the range of an out_w-bit two's complement word.
  // The caller truncates the 32-bit result to out_w bits.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int out_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/adc_sample_conditioner_if.sv
// Sample stream interface of the conditioner: raw ADC words in,
// conditioned signed samples and the sticky clip flag out.
interface adc_sample_conditioner_if
  import cond_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0]        din;
  logic                         din_valid;
  logic                         clr_clip;
  logic signed [DATA_WIDTH-1:0] dout;
  logic                         dout_valid;
  logic                         clip;

  modport master (
    output din,
    output din_valid,
    output clr_clip,
    input  dout,
    input  dout_valid,
    input  clip
  );

  modport slave (
    input  din,
    input  din_valid,
    input  clr_clip,
    output dout,
    output dout_valid,
    output clip
  );

endinterface

// File: rtl/cond_dc_tracker.sv
// Leaky first-order DC estimator. The first accepted sample preloads the
// accumulator so the loop starts settled; afterwards the accumulator leaks
// by 2^-DC_SHIFT per sample. Only built with COND_DC_BLOCK_EN.
module cond_dc_tracker
  import cond_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DC_SHIFT   = DEF_DC_SHIFT
) (
  input  logic                         clk_in,
  input  logic                         RST,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] x_s,
  output logic signed [DATA_WIDTH-1:0] dc_est,
  output logic                         preload
);

  localparam int ACC_W = DATA_WIDTH + DC_SHIFT;

  cond_state_e             state;
  logic signed [ACC_W-1:0] dc_acc;
  logic signed [ACC_W-1:0] acc_next;

  // Estimate always reflects the accumulator before this sample's update.
  assign dc_est  = DATA_WIDTH'(dc_acc >>> DC_SHIFT);
  assign preload = (state == INIT);

  // Intermediate terms may wrap, but the settled sum always fits ACC_W bits.
  assign acc_next = dc_acc + ACC_W'(x_s) - ACC_W'(dc_est);

  // INIT/RUN sequencing and accumulator update.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      state  <= INIT;
      dc_acc <= '0;
    end else if (sample_valid) begin
      case (state)
        INIT: begin
          dc_acc <= ACC_W'(x_s) <<< DC_SHIFT;
          state  <= RUN;
        end
        RUN: begin
          dc_acc <= acc_next;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: rtl/adc_sample_conditioner.sv
// ADC sample conditioner: offset-binary to signed conversion, optional DC
// removal, and box-car decimation by 2^DEC_LOG2.
// Optional feature macro: COND_DC_BLOCK_EN builds the DC tracker; without it
// the samples pass straight to the decimator and clip never sets.
module adc_sample_conditioner
  import cond_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEC_LOG2   = DEF_DEC_LOG2,
  parameter int DC_SHIFT   = DEF_DC_SHIFT
) (
  input  logic                     clk_in,
  input  logic                     RST,
  adc_sample_conditioner_if.slave  bus
);

  localparam int DW1   = DATA_WIDTH + 1;
  localparam int SUM_W = DATA_WIDTH + DEC_LOG2;
  localparam int CNT_W = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  // With DEC_LOG2 = 0 the last count is 0, so every sample closes a block.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DEC_LOG2) - 1);

  logic signed [DATA_WIDTH-1:0] x_s;
  logic                         v1;
  logic signed [DATA_WIDTH-1:0] dc_est;
  logic                         preload;
  logic signed [DW1-1:0]        diff;
  logic signed [DATA_WIDTH-1:0] y_sat;
  logic signed [DATA_WIDTH-1:0] y;
  logic                         sat_hit;
  logic signed [SUM_W-1:0]      sum;
  logic signed [SUM_W-1:0]      total;
  logic [CNT_W-1:0]             cnt;
  logic signed [DATA_WIDTH-1:0] dout_r;
  logic                         dout_valid_r;
  logic                         clip_r;

  // Stage 1: capture the sample, flipping the MSB to make it two's complement.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      x_s <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= bus.din_valid;
      if (bus.din_valid) begin
        x_s <= {~bus.din[DATA_WIDTH-1], bus.din[DATA_WIDTH-2:0]};
      end
    end
  end

`ifdef COND_DC_BLOCK_EN
  cond_dc_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .DC_SHIFT   (DC_SHIFT)
  ) u_dc_tracker (
    .clk_in       (clk_in),
    .RST          (RST),
    .sample_valid (v1),
    .x_s          (x_s),
    .dc_est       (dc_est),
    .preload      (preload)
  );
`else
  assign dc_est  = '0;
  assign preload = 1'b0;
`endif

  // One extra bit keeps the subtraction exact before clamping back down.
  assign diff    = DW1'(x_s) - DW1'(dc_est);
  assign y_sat   = DATA_WIDTH'(sat_signed(32'(diff), DATA_WIDTH));
  assign sat_hit = v1 && !preload && (diff != DW1'(y_sat));
  assign y       = preload ? '0 : y_sat;
  assign total   = sum + SUM_W'(y);

  // Stage 2: decimating accumulator, output register and sticky clip flag.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      sum          <= '0;
      cnt          <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      clip_r       <= 1'b0;
    end else begin
      dout_valid_r <= 1'b0;
      clip_r       <= sat_hit | (clip_r & ~bus.clr_clip);
      if (v1) begin
        if (cnt == CNT_LAST) begin
          dout_r       <= DATA_WIDTH'(total >>> DEC_LOG2);
          dout_valid_r <= 1'b1;
          sum          <= '0;
          cnt          <= '0;
        end else begin
          sum <= total;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.clip       = clip_r;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed bench for adc_sample_conditioner with a queue scoreboard.
module tb_adc_sample_conditioner;
  import cond_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int DL = DEF_DEC_LOG2;
  localparam int DS = DEF_DC_SHIFT;

  logic clk_in = 1'b0;
  logic RST;

  always #5 clk_in = ~clk_in;

  adc_sample_conditioner_if #(.DATA_WIDTH(DW)) bus ();

  adc_sample_conditioner #(
    .DATA_WIDTH (DW),
    .DEC_LOG2   (DL),
    .DC_SHIFT   (DS)
  ) dut (
    .clk_in (clk_in),
    .RST    (RST),
    .bus    (bus)
  );

  typedef struct {
    logic signed [DW-1:0] val;
    int                   due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   prev_v = 1'b0;

  longint               m_sum;
  int                   m_cnt;
  bit                   m_init;
  longint               m_acc;
  logic signed [DW-1:0] last_exp;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_sum  = 0;
    m_cnt  = 0;
    m_init = 1'b1;
    m_acc  = 0;
    sb.delete();
  endtask

  // Behavioural reference for one accepted sample driven in cycle cyc.
  task automatic model_push(input logic [DW-1:0] d);
    int   x;
    int   y;
    int   est;
    int   lo;
    int   hi;
    exp_t e;
    lo = -(1 << (DW - 1));
    hi = (1 << (DW - 1)) - 1;
    x  = int'(d) - (1 << (DW - 1));
`ifdef COND_DC_BLOCK_EN
    if (m_init) begin
      m_acc  = longint'(x) <<< DS;
      y      = 0;
      m_init = 1'b0;
    end else begin
      est   = int'(m_acc >>> DS);
      y     = x - est;
      if (y > hi) y = hi;
      if (y < lo) y = lo;
      m_acc = m_acc + x - est;
    end
`else
    est = 0;
    y   = x + est;
`endif
    m_sum += y;
    m_cnt++;
    if (m_cnt == (1 << DL)) begin
      e.val    = DW'(m_sum >>> DL);
      e.due    = cyc + 2;
      last_exp = e.val;
      sb.push_back(e);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 after gap idle cycles.
  task automatic send(input logic [DW-1:0] d, input int gap);
    bus.din       = d;
    bus.din_valid = 1'b1;
    model_push(d);
    @(posedge clk_in); #1;
    bus.din_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    @(negedge clk_in);
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
    chk("rst_clip", 32'(bus.clip), 32'h0);
    @(posedge clk_in); #1;
    RST = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk_in);
    #1;
    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL drain pending=%0d want=0", sb.size());
    end
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk_in) begin
    if (RST) begin
      prev_v = 1'b0;
    end else begin
      if (bus.dout_valid) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_pulse dout=%0d want=none", bus.dout);
        end
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          checks++;
          assert (bus.dout === mon_e.val) else begin
            errors++;
            $error("FAIL dout_value got=%0d want=%0d", bus.dout, mon_e.val);
          end
          checks++;
          assert (cyc === mon_e.due) else begin
            errors++;
            $error("FAIL dout_latency got_cycle=%0d want_cycle=%0d", cyc, mon_e.due);
          end
        end
        checks++;
        assert (prev_v === 1'b0) else begin
          errors++;
          $error("FAIL pulse_width got=2+ cycles want=1");
        end
      end
      prev_v = bus.dout_valid;
    end
  end

  initial begin
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.clr_clip  = 1'b0;
    RST           = 1'b1;
    model_reset();
    last_exp      = '0;
    @(posedge clk_in); #1;

    // Reset held with din_valid toggling: outputs stay quiet.
    for (int i = 0; i < 6; i++) begin
      bus.din       = 12'h900;
      bus.din_valid = i[0];
      @(negedge clk_in);
      chk("hold_rst_dout", 32'(bus.dout), 32'h0);
      chk("hold_rst_valid", 32'(bus.dout_valid), 32'h0);
      chk("hold_rst_clip", 32'(bus.clip), 32'h0);
      @(posedge clk_in); #1;
    end
    bus.din_valid = 1'b0;

    // Release with a sample in the same cycle, sparse valids.
    RST = 1'b0;
    send(12'h801, 2);
    send(12'h802, 2);
    send(12'h803, 2);
    send(12'h804, 2);
    // Back-to-back -1 samples.
    for (int i = 0; i < 4; i++) send(12'h7FF, 0);
    drain();
    repeat (3) @(posedge clk_in);
    #1;
    chk("dout_hold", 32'(bus.dout), 32'(last_exp));

    // Range extremes and floor rounding of a negative average.
    for (int i = 0; i < 4; i++) send(12'h000, 0);
    for (int i = 0; i < 4; i++) send(12'hFFF, 1);
    send(12'h7FF, 0);
    for (int i = 0; i < 3; i++) send(12'h800, 0);
    drain();

`ifdef COND_DC_BLOCK_EN
    // Constant input after preload removes fully.
    do_reset();
    for (int i = 0; i < 64; i++) send(12'hC00, 0);
    drain();
    chk("const_clip", 32'(bus.clip), 32'h0);

    // Step response decays toward zero.
    do_reset();
    for (int i = 0; i < 4; i++) send(12'h800, 0);
    for (int i = 0; i < 16; i++) send(12'hC00, 1);
    drain();

    // Saturation sets clip; clear in the same cycle loses to set.
    do_reset();
    send(12'hFFF, 0);
    send(12'h000, 0);
    bus.clr_clip = 1'b1;
    @(posedge clk_in); #1;
    chk("clip_set_wins", 32'(bus.clip), 32'h1);
    @(posedge clk_in); #1;
    bus.clr_clip = 1'b0;
    chk("clip_cleared", 32'(bus.clip), 32'h0);
    send(12'h800, 0);
    send(12'h800, 0);
    drain();
`endif

    // Reset mid-block leaves no residue in the next block.
    do_reset();
    send(12'hF00, 0);
    send(12'hF00, 0);
    do_reset();
    for (int i = 0; i < 4; i++) send(12'h804, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
